// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad encoder.
// The keymap is indexed {row, col} and holds the hex code driven to the display path.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 8;
    localparam int unsigned SCAN_CYCLES_DEFAULT     = 4;

    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to all-ones
// so idle pulled-up lines read as released during and after reset.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// Column-scanning 4x4 keypad encoder: debounces one key at a time and emits a
// single key_valid pulse per accepted press, holding key until the next press.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SCAN_CYCLES     = SCAN_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYCLES > SCAN_CYCLES) ? DEBOUNCE_CYCLES : SCAN_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] SC_LAST = CW'(SCAN_CYCLES - 1);

    logic [3:0]    rows_s;
    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_q, key_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;
    logic [1:0]    low_row;
    logic          row_up;

    sync2 #(
        .WIDTH(4)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rows),
        .q    (rows_s)
    );

    // Descending scan so the lowest-index low row is the last one written.
    always_comb begin
        low_row = 2'd0;
        for (int unsigned r = 4; r > 0; r--) begin
            if (!rows_s[r-1]) low_row = 2'(r - 1);
        end
    end

    assign row_up = rows_s[row_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SCAN;
            col_q   <= '0;
            row_q   <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        valid_d = 1'b0;
        held_d  = held_q;

        case (state_q)
            SCAN: begin
                if (dwell_q == SC_LAST) begin
                    dwell_d = '0;
                    if (rows_s != 4'b1111) begin
                        row_d   = low_row;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + CW'(1);
                end
            end

            // dwell is already zero here, so a return to SCAN gets a full dwell on the next column
            DEBOUNCE: begin
                if (row_up) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                end else if (cnt_q == DB_LAST) begin
                    key_d   = KEYMAP[{row_q, col_q}];
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            HELD: begin
                if (row_up) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (!row_up) begin
                    state_d = HELD;
                end else if (cnt_q == DB_LAST) begin
                    held_d  = 1'b0;
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = SCAN;
        endcase
    end

    assign cols      = ~(4'b0001 << col_q);
    assign key       = key_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: a keypad that closes rows onto driven
// columns, plus a press-level reference model tracked against the outputs.
module tb_keypad_encoder;

    localparam int DB = 8;
    localparam int SC = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    int tests = 0;
    int fails = 0;

    string keymap_s = "123A456B789CE0FD";

    always #5 clk = ~clk;

    keypad_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .SCAN_CYCLES    (SC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key      (key),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if ((pressed[r*4 +: 4] & ~cols) != 4'h0) rows[r] = 1'b0;
        end
    end

    function automatic logic [3:0] hexval(input int k);
        byte ch;
        ch = keymap_s[k];
        if (ch >= "A") return 4'(ch - "A" + 10);
        return 4'(ch - "0");
    endfunction

    function automatic int col_of(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (!c[i]) return i;
        return 0;
    endfunction

    // Reference model: mode 0 scanning, 1 confirming a press, 2 holding, 3 confirming release.
    int         m_mode, m_dwell, m_run, m_row;
    logic [3:0] m_cols, m_key, s1, s2;
    logic       m_valid, m_held;

    task automatic m_reset();
        m_mode = 0; m_dwell = 0; m_run = 0; m_row = 0;
        m_cols = 4'b1110; m_key = 4'h0; m_valid = 1'b0; m_held = 1'b0;
        s1 = 4'hF; s2 = 4'hF;
    endtask

    task automatic m_step();
        logic [3:0] pins;
        int         c;
        logic       up;
        c    = col_of(m_cols);
        pins = 4'hF;
        for (int r = 0; r < 4; r++) if (pressed[r*4 + c]) pins[r] = 1'b0;
        up      = s2[m_row];
        m_valid = 1'b0;
        case (m_mode)
            0: begin
                m_dwell++;
                if (m_dwell == SC) begin
                    m_dwell = 0;
                    if (s2 != 4'hF) begin
                        m_row = 3;
                        for (int r = 3; r >= 0; r--) if (!s2[r]) m_row = r;
                        m_run  = 0;
                        m_mode = 1;
                    end else begin
                        m_cols = {m_cols[2:0], m_cols[3]};
                    end
                end
            end
            1: begin
                if (up) begin
                    m_mode = 0;
                    m_cols = {m_cols[2:0], m_cols[3]};
                end else begin
                    m_run++;
                    if (m_run == DB) begin
                        m_key = hexval(m_row*4 + c); m_valid = 1'b1; m_held = 1'b1; m_mode = 2;
                    end
                end
            end
            2: if (up) begin m_run = 0; m_mode = 3; end
            default: begin
                if (!up) m_mode = 2;
                else begin
                    m_run++;
                    if (m_run == DB) begin
                        m_held = 1'b0; m_mode = 0;
                        m_cols = {m_cols[2:0], m_cols[3]};
                    end
                end
            end
        endcase
        s2 = s1;
        s1 = pins;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_reset();
            else m_step();
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({cols, key, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: cols=%b key=%h valid=%b held=%b, expected 1110 0 0 0", cols, key, key_valid, key_held);
        end
        reset = 1'b1;
    endtask

    task automatic test_idle();
        logic [3:0] exp_cols;
        for (int e = 1; e <= 32; e++) begin
            @(negedge clk);
            exp_cols = 4'b0001 << ((e / SC) % 4);
            exp_cols = ~exp_cols;
            tests++;
            if ({cols, key, key_valid, key_held} !== {exp_cols, 4'h0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL idle_rotation edge %0d: cols=%b key=%h valid=%b held=%b, expected cols=%b key=0 valid=0 held=0",
                         e, cols, key, key_valid, key_held, exp_cols);
            end
        end
    endtask

    task automatic test_press5();
        int pulses = 0;
        int n = 0;
        pressed[5] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            tests++;
            if ({cols, key, key_valid, key_held} !== {m_cols, m_key, m_valid, m_held}) begin
                fails++;
                $display("FAIL press5_model t=%0t: cols=%b key=%h valid=%b held=%b, expected %b %h %b %b",
                         $time, cols, key, key_valid, key_held, m_cols, m_key, m_valid, m_held);
            end
            if (key_valid) begin
                pulses++;
                tests++;
                if (key !== 4'h5) begin fails++; $display("FAIL press5_code: key=%h, expected 5", key); end
            end
        end
        tests++;
        if (pulses != 1 || key_held !== 1'b1) begin
            fails++;
            $display("FAIL press5_pulse: pulses=%0d held=%b, expected 1 pulse and held=1", pulses, key_held);
        end
        pressed[5] = 1'b0;
        while (key_held === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n != DB + 3) begin
            fails++;
            $display("FAIL press5_release: held fell after %0d cycles, expected %0d", n, DB + 3);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int n = 0;
        while (cols !== 4'b1101 && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (cols !== 4'b1101) begin fails++; $display("FAIL bounce_wait_col1: cols=%b, expected 1101", cols); end
        for (int i = 0; i < 10; i++) begin
            pressed[5] = ((i / 2) % 2) == 0;
            @(negedge clk);
            if (key_valid) pulses++;
            tests++;
            if ({cols, key, key_valid, key_held} !== {m_cols, m_key, m_valid, m_held}) begin
                fails++;
                $display("FAIL bounce_model t=%0t: cols=%b key=%h valid=%b held=%b, expected %b %h %b %b",
                         $time, cols, key, key_valid, key_held, m_cols, m_key, m_valid, m_held);
            end
        end
        tests++;
        if (pulses != 0) begin fails++; $display("FAIL bounce_quiet: pulses=%0d, expected 0", pulses); end
        pressed[5] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (key_valid) pulses++;
            tests++;
            if ({cols, key, key_valid, key_held} !== {m_cols, m_key, m_valid, m_held}) begin
                fails++;
                $display("FAIL bounce_model t=%0t: cols=%b key=%h valid=%b held=%b, expected %b %h %b %b",
                         $time, cols, key, key_valid, key_held, m_cols, m_key, m_valid, m_held);
            end
        end
        tests++;
        if (pulses != 1 || key !== 4'h5) begin
            fails++;
            $display("FAIL bounce_accept: pulses=%0d key=%h, expected 1 pulse key=5", pulses, key);
        end
        pressed[5] = 1'b0;
        n = 0;
        while (key_held === 1'b1 && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (key_held !== 1'b0) begin fails++; $display("FAIL bounce_release: held=%b, expected 0", key_held); end
    endtask

    task automatic test_release_glitch();
        int pulses = 0;
        int drops = 0;
        int n = 0;
        pressed[5] = 1'b1;
        while (key_held !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        tests++;
        if (key_held !== 1'b1) begin fails++; $display("FAIL glitch_hold: held=%b, expected 1", key_held); end
        for (int i = 0; i < 43; i++) begin
            pressed[5] = !(i >= 20 && i < 23);
            @(negedge clk);
            if (key_valid) pulses++;
            if (!key_held) drops++;
            tests++;
            if ({cols, key, key_valid, key_held} !== {m_cols, m_key, m_valid, m_held}) begin
                fails++;
                $display("FAIL glitch_model t=%0t: cols=%b key=%h valid=%b held=%b, expected %b %h %b %b",
                         $time, cols, key, key_valid, key_held, m_cols, m_key, m_valid, m_held);
            end
        end
        tests++;
        if (pulses != 0 || drops != 0) begin
            fails++;
            $display("FAIL glitch_ignored: pulses=%0d held-low cycles=%0d, expected 0 and 0", pulses, drops);
        end
        pressed[5] = 1'b0;
        n = 0;
        while (key_held === 1'b1 && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (key_held !== 1'b0) begin fails++; $display("FAIL glitch_release: held=%b, expected 0", key_held); end
    endtask

    task automatic test_rollover();
        int pulses = 0;
        int n = 0;
        pressed[3]  = 1'b1;
        pressed[15] = 1'b1;
        while (key_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        tests++;
        if (key_valid !== 1'b1 || key !== 4'hA) begin
            fails++;
            $display("FAIL rollover_priority: valid=%b key=%h, expected valid=1 key=A", key_valid, key);
        end
        pressed[12] = 1'b1;
        pressed[13] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (key_valid) pulses++;
            tests++;
            if ({cols, key, key_valid, key_held} !== {m_cols, m_key, m_valid, m_held}) begin
                fails++;
                $display("FAIL rollover_model t=%0t: cols=%b key=%h valid=%b held=%b, expected %b %h %b %b",
                         $time, cols, key, key_valid, key_held, m_cols, m_key, m_valid, m_held);
            end
        end
        tests++;
        if (pulses != 0 || key !== 4'hA) begin
            fails++;
            $display("FAIL rollover_ignored: pulses=%0d key=%h, expected 0 pulses key=A", pulses, key);
        end
        pressed = '0;
        n = 0;
        while (key_held === 1'b1 && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (key_held !== 1'b0) begin fails++; $display("FAIL rollover_release: held=%b, expected 0", key_held); end
    endtask

    task automatic test_sweep();
        int n;
        int pulses;
        for (int k = 0; k < 16; k++) begin
            if (k == 9) begin
                pressed[k] = 1'b1;
                n = 0;
                while (m_mode != 1 && n < 60) begin @(negedge clk); n++; end
                repeat (3) @(negedge clk);
                #2 reset = 1'b0;
                #1;
                tests++;
                if ({cols, key, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
                    fails++;
                    $display("FAIL sweep_async_reset: cols=%b key=%h valid=%b held=%b, expected 1110 0 0 0",
                             cols, key, key_valid, key_held);
                end
                @(negedge clk);
                pressed = '0;
                reset   = 1'b1;
                pulses  = 0;
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    if (key_valid) pulses++;
                    tests++;
                    if ({cols, key, key_valid, key_held} !== {m_cols, m_key, m_valid, m_held}) begin
                        fails++;
                        $display("FAIL sweep_model t=%0t: cols=%b key=%h valid=%b held=%b, expected %b %h %b %b",
                                 $time, cols, key, key_valid, key_held, m_cols, m_key, m_valid, m_held);
                    end
                end
                tests++;
                if (pulses != 0) begin fails++; $display("FAIL sweep_reset_nopulse: pulses=%0d, expected 0", pulses); end
            end
            pressed[k] = 1'b1;
            n = 0;
            while (key_valid !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
                tests++;
                if ({cols, key, key_valid, key_held} !== {m_cols, m_key, m_valid, m_held}) begin
                    fails++;
                    $display("FAIL sweep_model t=%0t: cols=%b key=%h valid=%b held=%b, expected %b %h %b %b",
                             $time, cols, key, key_valid, key_held, m_cols, m_key, m_valid, m_held);
                end
            end
            tests++;
            if (key_valid !== 1'b1 || key !== hexval(k)) begin
                fails++;
                $display("FAIL sweep_code key%0d: valid=%b key=%h, expected valid=1 key=%h", k, key_valid, key, hexval(k));
            end
            pressed = '0;
            n = 0;
            while (key_held === 1'b1 && n < 40) begin @(negedge clk); n++; end
            tests++;
            if (key_held !== 1'b0) begin fails++; $display("FAIL sweep_release key%0d: held=%b, expected 0", k, key_held); end
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press5();
        test_bounce();
        test_release_glitch();
        test_rollover();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
